rs_dispatch_arbiter: RTL and testbench

- Dispatch scheduler between the issue queue head and the reservation stations (RS) of the out-of-order OTTER.
- Each cycle it decides whether the head task can dispatch, and to which free RS of the task's class.
- Owns the authoritative RS busy vector: bits set on grant, cleared on release pulses from the RS/CDB side.
- Also counts structural-stall cycles and sequences a pipeline flush.

---
 rtl/rs_dispatch_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_rs_dispatch_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dispatch_arbiter.sv
// rs_dispatch_arbiter
//
// Dispatch scheduler that sits between the issue-queue head and the reservation
// stations (RS). Each cycle it decides whether the head task may dispatch and, if
// so, which free RS of the task's class receives it. The block owns the busy
// vector for every RS. A grant sets a bit and a release pulse clears it. The block
// also counts structural-stall cycles and sequences a pipeline flush.
//
// The busy vector is laid out as {ALU RS, LOAD RS, STORE RS}, with the store RS in
// the low bits.
//
// Build option:
//   RS_ARB_FIXED_PRIO_EN  - when defined, the lowest-index free RS of the class
//                           wins and no round-robin pointers exist. When it is
//                           undefined (the default), each class uses round-robin
//                           selection.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   TASK_VALID  in   issue-queue head holds a valid task
//   TASK_CLASS  in   head task class: 0=ALU, 1=LOAD, 2=STORE, 3=ALU
//   TASK_READY  out  head dispatches this cycle (independent of TASK_VALID)
//   RS_GRANT    out  one-hot target RS when TASK_VALID && TASK_READY, else 0
//   RS_RELEASE  in   per-RS single-cycle pulse that marks the RS as freed
//   FLUSH       in   flush request (level)
//   BUSY        out  registered busy vector
//   FLUSHING    out  high while in the flush state
//   STALL_CNT   out  saturating count of structural-stall cycles

module rs_dispatch_arbiter #(
    parameter int unsigned NUM_STORE_RS = 2,
    parameter int unsigned NUM_LOAD_RS  = 2,
    parameter int unsigned NUM_ALU_RS   = 2,
    parameter int unsigned STALL_CNT_W  = 16,
    localparam int unsigned NUM_RS = NUM_STORE_RS + NUM_LOAD_RS + NUM_ALU_RS
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   TASK_VALID,
    input  logic [1:0]             TASK_CLASS,
    output logic                   TASK_READY,
    output logic [NUM_RS-1:0]      RS_GRANT,
    input  logic [NUM_RS-1:0]      RS_RELEASE,
    input  logic                   FLUSH,
    output logic [NUM_RS-1:0]      BUSY,
    output logic                   FLUSHING,
    output logic [STALL_CNT_W-1:0] STALL_CNT
);

    localparam int unsigned LOAD_BASE = NUM_STORE_RS;
    localparam int unsigned ALU_BASE  = NUM_STORE_RS + NUM_LOAD_RS;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    typedef enum logic [0:0] {
        StRun,
        StFlush
    } state_e;

    state_e                   state_q, state_d;
    logic [NUM_RS-1:0]        busy_q, busy_d;
    logic [STALL_CNT_W-1:0]   stall_q, stall_d;

    // Search start offset of each class, local to the class.
    int st_start, ld_start, alu_start;

    // Selected class and its search result.
    logic               is_store, is_load, is_alu;
    int                 cls_base, cls_num, cls_start;
    int                 sel;
    logic [NUM_RS-1:0]  cand;
    logic               run_ok;
    logic               dispatch;

    // Walk the class circularly, starting at 'start'. Return the local index of the
    // first free RS, or -1 when every RS of the class is busy.
    function automatic int pick_free(input logic [NUM_RS-1:0] busy, input int base,
                                     input int num, input int start);
        int idx;
        pick_free = -1;
        for (int k = 0; k < int'(NUM_RS); k++) begin
            if (k < num) begin
                idx = start + k;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (pick_free < 0 && !busy[base + idx]) begin
                    pick_free = idx;
                end
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Class decode and free-RS selection
    // ------------------------------------------------------------------
    always_comb begin
        is_store  = 1'b0;
        is_load   = 1'b0;
        is_alu    = 1'b0;
        cls_base  = int'(ALU_BASE);
        cls_num   = int'(NUM_ALU_RS);
        cls_start = alu_start;
        case (TASK_CLASS)
            2'd1: begin
                is_load   = 1'b1;
                cls_base  = int'(LOAD_BASE);
                cls_num   = int'(NUM_LOAD_RS);
                cls_start = ld_start;
            end
            2'd2: begin
                is_store  = 1'b1;
                cls_base  = 0;
                cls_num   = int'(NUM_STORE_RS);
                cls_start = st_start;
            end
            default: begin
                is_alu = 1'b1;
            end
        endcase

        // Only registered busy bits are used here. A release in this cycle does
        // not make its RS grantable until the next cycle.
        sel  = pick_free(busy_q, cls_base, cls_num, cls_start);
        cand = '0;
        if (sel >= 0) begin
            cand[cls_base + sel] = 1'b1;
        end
    end

    // Gating with RST_N keeps the outputs quiet while reset is held, even though
    // the reset state itself would otherwise advertise free RS.
    assign run_ok     = RST_N && (state_q == StRun) && !FLUSH;
    assign TASK_READY = run_ok && (sel >= 0);
    assign dispatch   = TASK_VALID && TASK_READY;
    assign RS_GRANT   = dispatch ? cand : '0;

    // ------------------------------------------------------------------
    // Round-robin pointers (absent in the fixed-priority build)
    // ------------------------------------------------------------------
`ifdef RS_ARB_FIXED_PRIO_EN
    always_comb begin
        st_start  = 0;
        ld_start  = 0;
        alu_start = 0;
    end
`else
    localparam int unsigned ST_PW  = (NUM_STORE_RS > 1) ? $clog2(NUM_STORE_RS) : 1;
    localparam int unsigned LD_PW  = (NUM_LOAD_RS > 1)  ? $clog2(NUM_LOAD_RS)  : 1;
    localparam int unsigned ALU_PW = (NUM_ALU_RS > 1)   ? $clog2(NUM_ALU_RS)   : 1;

    // Each pointer holds the slot just after the last-granted RS, so the next
    // search starts there. A cleared pointer (reset or flush) behaves as if the
    // last RS of the class was granted most recently, which makes the lowest RS
    // the first candidate.
    logic [ST_PW-1:0]  st_ptr_q, st_ptr_d;
    logic [LD_PW-1:0]  ld_ptr_q, ld_ptr_d;
    logic [ALU_PW-1:0] alu_ptr_q, alu_ptr_d;
    int                nxt;

    assign st_start  = int'(st_ptr_q);
    assign ld_start  = int'(ld_ptr_q);
    assign alu_start = int'(alu_ptr_q);

    always_comb begin
        st_ptr_d  = st_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        alu_ptr_d = alu_ptr_q;
        nxt       = sel + 1;
        if (nxt >= cls_num) begin
            nxt = 0;
        end
        if (state_q != StRun || FLUSH) begin
            st_ptr_d  = '0;
            ld_ptr_d  = '0;
            alu_ptr_d = '0;
        end else if (dispatch) begin
            if (is_store) st_ptr_d  = ST_PW'(nxt);
            if (is_load)  ld_ptr_d  = LD_PW'(nxt);
            if (is_alu)   alu_ptr_d = ALU_PW'(nxt);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_ptr_q  <= '0;
            ld_ptr_q  <= '0;
            alu_ptr_q <= '0;
        end else begin
            st_ptr_q  <= st_ptr_d;
            ld_ptr_q  <= ld_ptr_d;
            alu_ptr_q <= alu_ptr_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // State, busy vector and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        stall_d = stall_q;

        unique case (state_q)
            StRun: begin
                if (FLUSH) begin
                    // No dispatch on the entry edge. All in-flight RS contents
                    // are discarded.
                    state_d = StFlush;
                    busy_d  = '0;
                end else begin
                    busy_d = (busy_q & ~RS_RELEASE) | RS_GRANT;
                end
            end
            StFlush: begin
                busy_d = '0;
                if (!FLUSH) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
                busy_d  = '0;
            end
        endcase

        if (state_q == StRun && !FLUSH && TASK_VALID && !TASK_READY &&
            stall_q != STALL_MAX) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StRun;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
        end
    end

    assign BUSY      = busy_q;
    assign FLUSHING  = (state_q == StFlush);
    assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_rs_dispatch_arbiter.sv
// Self-checking bench for rs_dispatch_arbiter: directed scenarios plus randomized
// traffic, all compared against a behavioural model of RS occupancy.

module tb_rs_dispatch_arbiter;

    localparam int NRS = 6;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        TASK_VALID;
    logic [1:0]  TASK_CLASS;
    logic        TASK_READY;
    logic [5:0]  RS_GRANT;
    logic [5:0]  RS_RELEASE;
    logic        FLUSH;
    logic [5:0]  BUSY;
    logic        FLUSHING;
    logic [15:0] STALL_CNT;

    rs_dispatch_arbiter dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .TASK_VALID (TASK_VALID),
        .TASK_CLASS (TASK_CLASS),
        .TASK_READY (TASK_READY),
        .RS_GRANT   (RS_GRANT),
        .RS_RELEASE (RS_RELEASE),
        .FLUSH      (FLUSH),
        .BUSY       (BUSY),
        .FLUSHING   (FLUSHING),
        .STALL_CNT  (STALL_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_bad    = 0;

    // Model state. Class index: 0=store, 1=load, 2=alu.
    bit mbusy [NRS];
    int mlast [3];
    bit mflush;
    int mstall;
    int cbase [3] = '{0, 2, 4};
    int cnum  [3] = '{2, 2, 2};

    // Values observed during the most recent cycle() call, sampled before its edge.
    logic [5:0]  obs_grant, obs_busy;
    logic        obs_ready, obs_flushing;
    logic [15:0] obs_stall;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int cls_of(input logic [1:0] c);
        if (c == 2'd2) return 0;
        if (c == 2'd1) return 1;
        return 2;
    endfunction

    // Global index of the RS the model would grant for class cl, or -1.
    function automatic int model_pick(input int cl);
        int s;
`ifdef RS_ARB_FIXED_PRIO_EN
        s = 0;
`else
        s = (mlast[cl] + 1) % cnum[cl];
`endif
        for (int k = 0; k < cnum[cl]; k++) begin
            int i;
            i = (s + k) % cnum[cl];
            if (!mbusy[cbase[cl] + i]) return cbase[cl] + i;
        end
        return -1;
    endfunction

    task automatic model_clear_rs();
        for (int i = 0; i < NRS; i++) mbusy[i] = 1'b0;
        for (int c = 0; c < 3; c++) mlast[c] = cnum[c] - 1;
    endtask

    task automatic model_reset();
        model_clear_rs();
        mflush = 1'b0;
        mstall = 0;
    endtask

    // One clock cycle: drive inputs, check the outputs against the model, then
    // advance the model across the rising edge.
    task automatic cycle(input bit v, input logic [1:0] c, input logic [5:0] rel,
                         input bit f);
        int         cl, g;
        bit         exp_rdy;
        logic [5:0] exp_gnt, mb;
        @(negedge CLK);
        TASK_VALID = v;
        TASK_CLASS = c;
        RS_RELEASE = rel;
        FLUSH      = f;
        #1;
        cl      = cls_of(c);
        g       = model_pick(cl);
        exp_rdy = !mflush && !f && (g >= 0);
        exp_gnt = '0;
        if (v && exp_rdy) exp_gnt[g] = 1'b1;
        for (int i = 0; i < NRS; i++) mb[i] = mbusy[i];

        obs_grant    = RS_GRANT;
        obs_ready    = TASK_READY;
        obs_busy     = BUSY;
        obs_flushing = FLUSHING;
        obs_stall    = STALL_CNT;
        check_eq("ready", {31'b0, TASK_READY}, {31'b0, exp_rdy});
        check_eq("grant", {26'b0, RS_GRANT}, {26'b0, exp_gnt});
        check_eq("busy", {26'b0, BUSY}, {26'b0, mb});
        check_eq("flushing", {31'b0, FLUSHING}, {31'b0, mflush});
        check_eq("stall_cnt", {16'b0, STALL_CNT}, mstall);

        @(posedge CLK);
        if (!mflush) begin
            if (!f && v && !exp_rdy && mstall < 65535) mstall++;
            if (f) begin
                mflush = 1'b1;
                model_clear_rs();
            end else begin
                for (int i = 0; i < NRS; i++) if (rel[i]) mbusy[i] = 1'b0;
                if (v && exp_rdy) begin
                    mbusy[g]  = 1'b1;
                    mlast[cl] = g - cbase[cl];
                end
            end
        end else begin
            model_clear_rs();
            if (!f) mflush = 1'b0;
        end
    endtask

    // Reset asserted between edges. The outputs must clear at once, even while
    // TASK_VALID is high.
    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST_N      = 1'b0;
        TASK_VALID = 1'b1;
        TASK_CLASS = 2'd0;
        #1;
        check_eq("rst_ready", {31'b0, TASK_READY}, 0);
        check_eq("rst_grant", {26'b0, RS_GRANT}, 0);
        check_eq("rst_busy", {26'b0, BUSY}, 0);
        check_eq("rst_stall", {16'b0, STALL_CNT}, 0);
        check_eq("rst_flushing", {31'b0, FLUSHING}, 0);
        model_reset();
        TASK_VALID = 1'b0;
        RS_RELEASE = '0;
        FLUSH      = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int fcnt;
        bit f;
        RST_N      = 1'b1;
        TASK_VALID = 1'b0;
        TASK_CLASS = 2'd0;
        RS_RELEASE = '0;
        FLUSH      = 1'b0;
        model_reset();

        // ALU fill: two grants, then a stall.
        do_reset();
        cycle(1, 2'd0, 6'b0, 0);
        check_eq("tp1_g0", {26'b0, obs_grant}, 32'h10);
        cycle(1, 2'd0, 6'b0, 0);
        check_eq("tp1_g1", {26'b0, obs_grant}, 32'h20);
        cycle(1, 2'd0, 6'b0, 0);
        check_eq("tp1_rdy", {31'b0, obs_ready}, 0);
        cycle(0, 2'd0, 6'b0, 0);
        check_eq("tp1_busy", {26'b0, obs_busy}, 32'h30);
        check_eq("tp1_stall", {16'b0, obs_stall}, 1);

        // Store class with RS0 busy.
        do_reset();
        cycle(1, 2'd2, 6'b0, 0);
        cycle(1, 2'd2, 6'b0, 0);
        check_eq("tp2_grant", {26'b0, obs_grant}, 32'h02);
        check_eq("tp2_rdy", {31'b0, obs_ready}, 1);
        cycle(0, 2'd2, 6'b0, 0);
        check_eq("tp2_busy", {26'b0, obs_busy}, 32'h03);

        // A release is not bypassed into the current cycle.
        do_reset();
        cycle(1, 2'd1, 6'b0, 0);
        cycle(1, 2'd1, 6'b0, 0);
        cycle(1, 2'd1, 6'b000100, 0);
        check_eq("tp3_nobypass", {31'b0, obs_ready}, 0);
        cycle(1, 2'd1, 6'b0, 0);
        check_eq("tp3_grant", {26'b0, obs_grant}, 32'h04);

        // Load pointer at RS2, then release RS2 and RS3 (RS3 was not busy).
        do_reset();
        cycle(1, 2'd1, 6'b0, 0);
        cycle(0, 2'd1, 6'b001100, 0);
        cycle(1, 2'd1, 6'b0, 0);
`ifdef RS_ARB_FIXED_PRIO_EN
        check_eq("tp4_first", {26'b0, obs_grant}, 32'h04);
`else
        check_eq("tp4_first", {26'b0, obs_grant}, 32'h08);
`endif
        cycle(1, 2'd1, 6'b0, 0);
`ifdef RS_ARB_FIXED_PRIO_EN
        check_eq("tp4_second", {26'b0, obs_grant}, 32'h08);
`else
        check_eq("tp4_second", {26'b0, obs_grant}, 32'h04);
`endif

        // Flush with every RS busy.
        do_reset();
        cycle(1, 2'd2, 6'b0, 0);
        cycle(1, 2'd2, 6'b0, 0);
        cycle(1, 2'd1, 6'b0, 0);
        cycle(1, 2'd1, 6'b0, 0);
        cycle(1, 2'd0, 6'b0, 0);
        cycle(1, 2'd0, 6'b0, 0);
        cycle(1, 2'd0, 6'b0, 1);
        check_eq("tp5_full", {26'b0, obs_busy}, 32'h3f);
        check_eq("tp5_rdy0", {31'b0, obs_ready}, 0);
        cycle(1, 2'd0, 6'b0, 1);
        check_eq("tp5_fl1", {31'b0, obs_flushing}, 1);
        check_eq("tp5_busy0", {26'b0, obs_busy}, 0);
        cycle(1, 2'd0, 6'b0, 0);
        check_eq("tp5_fl2", {31'b0, obs_flushing}, 1);
        check_eq("tp5_rdy2", {31'b0, obs_ready}, 0);
        cycle(1, 2'd0, 6'b0, 0);
        check_eq("tp5_fl3", {31'b0, obs_flushing}, 0);
        check_eq("tp5_grant", {26'b0, obs_grant}, 32'h10);

        // Stall counter saturation.
        do_reset();
        cycle(1, 2'd0, 6'b0, 0);
        cycle(1, 2'd0, 6'b0, 0);
        for (int i = 0; i < 65541; i++) cycle(1, 2'd0, 6'b0, 0);
        cycle(0, 2'd0, 6'b0, 0);
        check_eq("tp6_sat", {16'b0, obs_stall}, 32'hffff);

        // Randomized traffic, with occasional flushes and resets.
        do_reset();
        fcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] rel;
            if (fcnt > 0) begin
                f = 1'b1;
                fcnt--;
            end else if ($urandom % 40 == 0) begin
                f    = 1'b1;
                fcnt = $urandom_range(0, 3);
            end else begin
                f = 1'b0;
            end
            rel = ($urandom % 3 == 0) ? 6'($urandom) : 6'b0;
            cycle(($urandom % 4) != 0, 2'($urandom), rel, f);
            if ($urandom % 500 == 0) begin
                do_reset();
                fcnt = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
